// File: rtl/round_sequencer.sv
// Round sequencer: BCD countdown timer with LFSR challenge digits.
// Option: ROUND_SEQUENCER_NO_REPEAT_EN forces consecutive digits to differ.
module round_sequencer #(
  parameter int          CLK_HZ     = 50000000,
  parameter int          ROUND_SECS = 60,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       reconfig,
  input  logic       enable,
  input  logic       next_req,
  output logic [3:0] morse_number,
  output logic       number_valid,
  output logic       timeout,
  output logic [3:0] secs_tens,
  output logic [3:0] secs_ones
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PMAX = PW'(CLK_HZ - 1);
  localparam logic [3:0] TENS0 = 4'(ROUND_SECS / 10);
  localparam logic [3:0] ONES0 = 4'(ROUND_SECS % 10);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    RUNNING,
    EXPIRED
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [PW-1:0]   presc;
  logic [7:0]      lfsr;
  logic            fb;
  logic            tick;
  logic            last_sec;
  logic            live;
  logic [3:0]      cand;
  logic [3:0]      pick;

  assign live     = (state == ARMED) || (state == RUNNING);
  assign tick     = (state == RUNNING) && enable && (presc == PMAX);
  assign last_sec = (secs_tens == 4'd0) && (secs_ones == 4'd1);
  assign fb       = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  assign cand     = (lfsr[3:0] > 4'd9) ? lfsr[3:0] - 4'd6 : lfsr[3:0];

`ifdef ROUND_SEQUENCER_NO_REPEAT_EN
  assign pick = (cand != morse_number) ? cand :
                (cand == 4'd9) ? 4'd0 : cand + 4'd1;
`else
  assign pick = cand;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state and status decode; reconfig overrides everything
  always_comb begin
    state_nx     = state;
    timeout      = 1'b0;
    number_valid = 1'b0;
    case (state)
      IDLE: ;
      ARMED: begin
        number_valid = 1'b1;
        if (enable) state_nx = RUNNING;
      end
      RUNNING: begin
        number_valid = 1'b1;
        if (tick && last_sec) state_nx = EXPIRED;
      end
      EXPIRED: timeout = 1'b1;
      default: state_nx = IDLE;
    endcase
    if (reconfig) state_nx = ARMED;
  end

  // Prescaler: runs only in RUNNING with enable, wraps on tick
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                            presc <= '0;
    else if (reconfig)                   presc <= '0;
    else if (state == RUNNING && enable) presc <= tick ? '0 : presc + 1'b1;
  end

  // BCD seconds countdown, digit-wise borrow
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      secs_tens <= 4'd0;
      secs_ones <= 4'd0;
    end else if (reconfig) begin
      secs_tens <= TENS0;
      secs_ones <= ONES0;
    end else if (tick) begin
      if (last_sec) begin
        secs_ones <= 4'd0;
      end else if (secs_ones == 4'd0) begin
        secs_ones <= 4'd9;
        secs_tens <= secs_tens - 4'd1;
      end else begin
        secs_ones <= secs_ones - 4'd1;
      end
    end
  end

  // Free-running LFSR, taps 8,6,5,4
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr <= LFSR_SEED;
    else      lfsr <= {lfsr[6:0], fb};
  end

  // Challenge digit: issued on arm and on requests during a live round
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                        morse_number <= 4'd0;
    else if (reconfig)               morse_number <= pick;
    else if (next_req && live)       morse_number <= pick;
  end

endmodule

// File: tb/tb_round_sequencer.sv
// Testbench for round_sequencer (CLK_HZ=4, ROUND_SECS=3).
// Integer reference model, directed phases plus randomized traffic.
module tb_round_sequencer;

  localparam int CLK_HZ = 4;
  localparam int RS     = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       reconfig = 1'b0;
  logic       enable = 1'b0;
  logic       next_req = 1'b0;
  logic [3:0] morse_number;
  logic       number_valid;
  logic       timeout;
  logic [3:0] secs_tens;
  logic [3:0] secs_ones;

  round_sequencer #(
    .CLK_HZ(CLK_HZ),
    .ROUND_SECS(RS),
    .LFSR_SEED(8'hA5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .reconfig(reconfig),
    .enable(enable),
    .next_req(next_req),
    .morse_number(morse_number),
    .number_valid(number_valid),
    .timeout(timeout),
    .secs_tens(secs_tens),
    .secs_ones(secs_ones)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // model: phase 0 idle, 1 armed, 2 running, 3 expired
  int m_phase, m_secs, m_cnt, m_lfsr, m_digit;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_secs  = 0;
    m_cnt   = 0;
    m_lfsr  = 'hA5;
    m_digit = 0;
  endtask

  function automatic int mdigit(int l, int cur);
    int c;
    c = l % 16;
    if (c > 9) c = c - 6;
`ifdef ROUND_SEQUENCER_NO_REPEAT_EN
    if (c == cur) c = (c + 1) % 10;
`endif
    return c;
  endfunction

  task automatic model_update(input logic rc, input logic en,
                              input logic nr);
    int c, fb;
    c  = mdigit(m_lfsr, m_digit);
    fb = ((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4)
          ^ (m_lfsr >> 3)) & 1;
    if (rc) begin
      m_phase = 1;
      m_secs  = RS;
      m_cnt   = 0;
      m_digit = c;
    end else if (m_phase == 1) begin
      if (nr) m_digit = c;
      if (en) m_phase = 2;
    end else if (m_phase == 2) begin
      if (nr) m_digit = c;
      if (en) begin
        if (m_cnt == CLK_HZ - 1) begin
          m_cnt  = 0;
          m_secs = m_secs - 1;
          if (m_secs == 0) m_phase = 3;
        end else begin
          m_cnt = m_cnt + 1;
        end
      end
    end
    m_lfsr = ((m_lfsr << 1) & 255) | fb;
  endtask

  task automatic check_outs();
    chk("morse", morse_number, m_digit);
    chk("valid", number_valid, (m_phase == 1 || m_phase == 2));
    chk("timeout", timeout, (m_phase == 3));
    chk("tens", secs_tens, m_secs / 10);
    chk("ones", secs_ones, m_secs % 10);
    chk("digit_range", (morse_number <= 4'd9), 1);
  endtask

  task automatic step(input logic rc, input logic en, input logic nr);
    reconfig = rc;
    enable   = en;
    next_req = nr;
    @(posedge clk);
    model_update(rc, en, nr);
    #1;
    check_outs();
  endtask

  function automatic bit will_expire(logic en);
    return m_phase == 2 && en && m_cnt == CLK_HZ - 1 && m_secs == 1;
  endfunction

  initial begin
    int n_en, reqs, rep;
    logic [3:0] prev;
    bit hit;

    // reset, then 50 idle cycles with stray requests
    model_reset();
    #2 rst = 1'b0;
    #1 check_outs();
    repeat (3) begin
      @(posedge clk);
      #1 check_outs();
    end
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 50; i++) step(1'b0, 1'b0, 1'($urandom % 2));

    // full round with enable held
    step(1'b1, 1'b1, 1'b0);
    n_en = 0;
    for (int i = 0; i < 40 && !timeout; i++) begin
      step(1'b0, 1'b1, 1'b0);
      n_en++;
    end
    chk("expired_timeout", timeout, 1);
    chk("expired_valid", number_valid, 0);
    chk("round_len", n_en, 13);

    // enable pause at 02 delays expiry by the pause length
    step(1'b1, 1'b0, 1'b0);
    n_en = 0;
    for (int i = 0; i < 40 && secs_ones != 4'd2; i++) begin
      step(1'b0, 1'b1, 1'b0);
      n_en++;
    end
    chk("paused_at", secs_ones, 2);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0);
    chk("frozen_ones", secs_ones, 2);
    chk("frozen_tout", timeout, 0);
    for (int i = 0; i < 40 && !timeout; i++) begin
      step(1'b0, 1'b1, 1'b0);
      n_en++;
    end
    chk("paused_round_len", n_en, 13);

    // 200 digit requests during live rounds
    step(1'b1, 1'b0, 1'b0);
    reqs = 0;
    for (int i = 0; i < 2000 && reqs < 200; i++) begin
      logic nr;
      nr = 1'($urandom % 2);
      if (timeout) begin
        step(1'b1, 1'b0, 1'b0);
      end else begin
        step(1'b0, 1'($urandom % 2), nr);
        if (nr) reqs++;
      end
    end
    chk("req_count", reqs, 200);

    // reconfig on the expiring tick wins
    step(1'b1, 1'b1, 1'b0);
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      if (will_expire(1'b1)) begin
        step(1'b1, 1'b1, 1'b1);
        hit = 1;
      end else begin
        step(1'b0, 1'b1, 1'b0);
      end
    end
    chk("rc_exp_timeout", timeout, 0);
    chk("rc_exp_ones", secs_ones, 3);
    chk("rc_exp_valid", number_valid, 1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0);

    // back-to-back requests in ARMED
    step(1'b1, 1'b0, 1'b0);
    prev = morse_number;
    rep = 0;
    for (int i = 0; i < 500; i++) begin
      step(1'b0, 1'b0, 1'b1);
      if (morse_number == prev) rep++;
      prev = morse_number;
    end
`ifdef ROUND_SEQUENCER_NO_REPEAT_EN
    chk("no_repeat", rep, 0);
`else
    chk("has_repeat", (rep > 0), 1);
`endif

    // asynchronous reset mid-round
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0);
    #2 rst = 1'b0;
    model_reset();
    #1 check_outs();
    @(posedge clk);
    #1 check_outs();
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1);

    // random traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom % 30 == 0), 1'($urandom % 4 != 0),
           1'($urandom % 3 == 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
